// File: rtl/alu_ctrl_decoder_if.sv
// Handshake and decoded-field bundle between the fetch side, the ALU-control decoder and the ALU stage.
interface alu_ctrl_decoder_if;
  logic [31:0] instr_w_i;
  logic        instr_valid_w_i_h;
  logic        instr_ready_w_o_h;
  logic        flush_w_i_h;
  logic        dec_valid_w_o_h;
  logic        dec_ready_w_i_h;
  logic [3:0]  alu_control_w_o;
  logic        addi_sub_flag_w_o;
  logic        store_force_add_flag_w_o;
  logic        b_sel_imm_w_o_h;
  logic [31:0] imm_w_o;
  logic        is_branch_w_o_h;
  logic [2:0]  branch_cond_w_o;
  logic        illegal_w_o_h;

  modport master (
    output instr_w_i, instr_valid_w_i_h, flush_w_i_h, dec_ready_w_i_h,
    input  instr_ready_w_o_h, dec_valid_w_o_h, alu_control_w_o, addi_sub_flag_w_o,
           store_force_add_flag_w_o, b_sel_imm_w_o_h, imm_w_o, is_branch_w_o_h,
           branch_cond_w_o, illegal_w_o_h
  );

  modport slave (
    input  instr_w_i, instr_valid_w_i_h, flush_w_i_h, dec_ready_w_i_h,
    output instr_ready_w_o_h, dec_valid_w_o_h, alu_control_w_o, addi_sub_flag_w_o,
           store_force_add_flag_w_o, b_sel_imm_w_o_h, imm_w_o, is_branch_w_o_h,
           branch_cond_w_o, illegal_w_o_h
  );
endinterface

// File: rtl/alu_ctrl_decoder.sv
// RV32I ALU-control decoder with output register plus one-entry skid buffer.
// Define ALU_DEC_ILLEGAL_TRAP_EN to flag illegal instructions instead of decoding them as a NOP.
module alu_ctrl_decoder #(
  parameter logic [3:0] ILLEGAL_ALU_CTRL = 4'b0000
) (
  input logic          clk_w_i,
  input logic          rst_w_i_l,
  alu_ctrl_decoder_if.slave bus
);

`ifdef ALU_DEC_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  alu_control;
    logic        addi_sub;
    logic        store_force_add;
    logic        b_sel_imm;
    logic [31:0] imm;
    logic        is_branch;
    logic [2:0]  branch_cond;
    logic        illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t       d;
    logic       bad;
    logic [2:0] f3;
    logic [6:0] f7;
    d   = '0;
    bad = 1'b0;
    f3  = w[14:12];
    f7  = w[31:25];
    if (w[1:0] != 2'b11) begin
      bad = 1'b1;
    end else begin
      case (w[6:0])
        7'b0110011: begin
          d.alu_control = {w[30], f3};
          d.addi_sub    = 1'b1;
          if (f7 == 7'b0000000) begin
            bad = 1'b0;
          end else if ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) begin
            bad = 1'b0;
          end else begin
            bad = 1'b1;
          end
        end
        7'b0010011: begin
          d.alu_control = {w[30], f3};
          d.b_sel_imm   = 1'b1;
          d.imm         = {{20{w[31]}}, w[31:20]};
          if (f3 == 3'b001) begin
            bad = (f7 != 7'b0000000);
          end else if (f3 == 3'b101) begin
            bad = !((f7 == 7'b0000000) || (f7 == 7'b0100000));
          end else begin
            bad = 1'b0;
          end
        end
        7'b0000011, 7'b1100111: begin
          d.b_sel_imm = 1'b1;
          d.imm       = {{20{w[31]}}, w[31:20]};
        end
        7'b0100011: begin
          d.b_sel_imm       = 1'b1;
          d.store_force_add = 1'b1;
          d.imm             = {{20{w[31]}}, w[31:25], w[11:7]};
        end
        7'b1100011: begin
          d.is_branch   = 1'b1;
          d.branch_cond = f3;
          d.imm         = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
          bad           = (f3 == 3'b010) || (f3 == 3'b011);
        end
        7'b0110111, 7'b0010111: begin
          d.b_sel_imm = 1'b1;
          d.imm       = {w[31:12], 12'h000};
        end
        7'b1101111: begin
          d.b_sel_imm = 1'b1;
          d.imm       = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        end
        default: begin
          bad = 1'b1;
        end
      endcase
    end
    // Illegal words either trap or collapse to ADDI x0,x0,0.
    if (bad) begin
      d             = '0;
      d.illegal     = TRAP_EN;
      d.alu_control = TRAP_EN ? ILLEGAL_ALU_CTRL : 4'b0000;
      d.b_sel_imm   = ~TRAP_EN;
    end else begin
      d.illegal = 1'b0;
    end
    return d;
  endfunction

  dec_t dec_s, out_r, skid_r, out_nxt_s, skid_nxt_s;
  logic out_vld_r, skid_vld_r, ready_r;
  logic out_vld_nxt_s, skid_vld_nxt_s;
  logic in_xfer_s, out_xfer_s;

  assign dec_s      = decode(bus.instr_w_i);
  assign in_xfer_s  = bus.instr_valid_w_i_h & ready_r & ~bus.flush_w_i_h;
  assign out_xfer_s = out_vld_r & bus.dec_ready_w_i_h;

  // Next-state of output and skid registers; ready_r guarantees no input while skid is full.
  always_comb begin
    out_nxt_s      = out_r;
    out_vld_nxt_s  = out_vld_r;
    skid_nxt_s     = skid_r;
    skid_vld_nxt_s = skid_vld_r;
    if (bus.flush_w_i_h) begin
      out_nxt_s      = '0;
      out_vld_nxt_s  = 1'b0;
      skid_nxt_s     = '0;
      skid_vld_nxt_s = 1'b0;
    end else if (!out_vld_r || out_xfer_s) begin
      if (skid_vld_r) begin
        out_nxt_s      = skid_r;
        out_vld_nxt_s  = 1'b1;
        skid_nxt_s     = '0;
        skid_vld_nxt_s = 1'b0;
      end else if (in_xfer_s) begin
        out_nxt_s     = dec_s;
        out_vld_nxt_s = 1'b1;
      end else begin
        out_vld_nxt_s = 1'b0;
      end
    end else if (in_xfer_s) begin
      skid_nxt_s     = dec_s;
      skid_vld_nxt_s = 1'b1;
    end else begin
      out_vld_nxt_s = out_vld_r;
    end
  end

  // Pipeline state registers, cleared asynchronously.
  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      out_r      <= '0;
      out_vld_r  <= 1'b0;
      skid_r     <= '0;
      skid_vld_r <= 1'b0;
      ready_r    <= 1'b1;
    end else begin
      out_r      <= out_nxt_s;
      out_vld_r  <= out_vld_nxt_s;
      skid_r     <= skid_nxt_s;
      skid_vld_r <= skid_vld_nxt_s;
      ready_r    <= ~skid_vld_nxt_s;
    end
  end

  assign bus.instr_ready_w_o_h        = ready_r;
  assign bus.dec_valid_w_o_h          = out_vld_r;
  assign bus.alu_control_w_o          = out_r.alu_control;
  assign bus.addi_sub_flag_w_o        = out_r.addi_sub;
  assign bus.store_force_add_flag_w_o = out_r.store_force_add;
  assign bus.b_sel_imm_w_o_h          = out_r.b_sel_imm;
  assign bus.imm_w_o                  = out_r.imm;
  assign bus.is_branch_w_o_h          = out_r.is_branch;
  assign bus.branch_cond_w_o          = out_r.branch_cond;
  assign bus.illegal_w_o_h            = out_r.illegal;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Directed self-checking bench for alu_ctrl_decoder: decode table, stall/skid, flush and mid-stall reset.
module tb_alu_ctrl_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_ctrl_decoder_if bus();

  alu_ctrl_decoder #(.ILLEGAL_ALU_CTRL(4'b1111)) dut (
    .clk_w_i  (clk),
    .rst_w_i_l(rst_n),
    .bus      (bus)
  );

  // {alu[3:0], addi_sub, store_force_add, b_sel_imm, imm[31:0], is_branch, branch_cond[2:0], illegal}
  function automatic logic [43:0] outs();
    return {bus.alu_control_w_o, bus.addi_sub_flag_w_o, bus.store_force_add_flag_w_o,
            bus.b_sel_imm_w_o_h, bus.imm_w_o, bus.is_branch_w_o_h, bus.branch_cond_w_o,
            bus.illegal_w_o_h};
  endfunction

  function automatic logic [43:0] mk(input logic [3:0] alu, input logic as, input logic sfa,
                                     input logic bs, input logic [31:0] imm, input logic isb,
                                     input logic [2:0] bc, input logic ill);
    return {alu, as, sfa, bs, imm, isb, bc, ill};
  endfunction

  function automatic logic [43:0] ill_exp();
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
    return mk(4'b1111, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b1);
`else
    return mk(4'b0000, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 3'b000, 1'b0);
`endif
  endfunction

  task automatic test_reset();
    #12;
    checks++;
    if (bus.dec_valid_w_o_h !== 1'b0 || bus.instr_ready_w_o_h !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: got valid=%b ready=%b expected valid=0 ready=1",
               bus.dec_valid_w_o_h, bus.instr_ready_w_o_h);
    end
    checks++;
    if (outs() !== 44'h0) begin
      errors++;
      $display("FAIL reset_outs: got %h expected 0", outs());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.dec_valid_w_o_h !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got valid=%b expected 0", bus.dec_valid_w_o_h);
    end
  endtask

  task automatic test_decode();
    logic [31:0] vi [16];
    logic [43:0] ve [16];
    vi[0]  = 32'h402081B3; ve[0]  = mk(4'b1000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0);
    vi[1]  = 32'h002081B3; ve[1]  = mk(4'b0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0);
    vi[2]  = 32'hFFF00093; ve[2]  = mk(4'b1000, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 3'b000, 1'b0);
    vi[3]  = 32'h4030D093; ve[3]  = mk(4'b1101, 1'b0, 1'b0, 1'b1, 32'h00000403, 1'b0, 3'b000, 1'b0);
    vi[4]  = 32'h0030D093; ve[4]  = mk(4'b0101, 1'b0, 1'b0, 1'b1, 32'h00000003, 1'b0, 3'b000, 1'b0);
    vi[5]  = 32'h0020A423; ve[5]  = mk(4'b0000, 1'b0, 1'b1, 1'b1, 32'h00000008, 1'b0, 3'b000, 1'b0);
    vi[6]  = 32'h00208463; ve[6]  = mk(4'b0000, 1'b0, 1'b0, 1'b0, 32'h00000008, 1'b1, 3'b000, 1'b0);
    vi[7]  = 32'hFFC12083; ve[7]  = mk(4'b0000, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 3'b000, 1'b0);
    vi[8]  = 32'h123450B7; ve[8]  = mk(4'b0000, 1'b0, 1'b0, 1'b1, 32'h12345000, 1'b0, 3'b000, 1'b0);
    vi[9]  = 32'h008000EF; ve[9]  = mk(4'b0000, 1'b0, 1'b0, 1'b1, 32'h00000008, 1'b0, 3'b000, 1'b0);
    vi[10] = 32'h00000000; ve[10] = ill_exp();
    vi[11] = 32'h022081B3; ve[11] = ill_exp();
    vi[12] = 32'h402091B3; ve[12] = ill_exp();
    vi[13] = 32'h40009093; ve[13] = ill_exp();
    vi[14] = 32'h0020A463; ve[14] = ill_exp();
    vi[15] = 32'h0000007F; ve[15] = ill_exp();
    bus.dec_ready_w_i_h = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.instr_w_i         = vi[i];
      bus.instr_valid_w_i_h = 1'b1;
      @(posedge clk); #1;
      bus.instr_valid_w_i_h = 1'b0;
      checks++;
      if (bus.dec_valid_w_o_h !== 1'b1 || outs() !== ve[i]) begin
        errors++;
        $display("FAIL decode[%0d] instr=%h: got valid=%b outs=%h expected valid=1 outs=%h",
                 i, vi[i], bus.dec_valid_w_o_h, outs(), ve[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.dec_valid_w_o_h !== 1'b0) begin
      errors++;
      $display("FAIL decode_drain: got valid=%b expected 0", bus.dec_valid_w_o_h);
    end
  endtask

  task automatic test_stall();
    logic [43:0] ea, eb;
    ea = mk(4'b1000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0);
    eb = mk(4'b1000, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 3'b000, 1'b0);
    bus.dec_ready_w_i_h   = 1'b0;
    bus.instr_w_i         = 32'h402081B3;
    bus.instr_valid_w_i_h = 1'b1;
    @(posedge clk); #1;
    bus.instr_w_i = 32'hFFF00093;
    checks++;
    if (bus.instr_ready_w_o_h !== 1'b1 || bus.dec_valid_w_o_h !== 1'b1 || outs() !== ea) begin
      errors++;
      $display("FAIL stall_first: got ready=%b valid=%b outs=%h expected ready=1 valid=1 outs=%h",
               bus.instr_ready_w_o_h, bus.dec_valid_w_o_h, outs(), ea);
    end
    @(posedge clk); #1;
    bus.instr_valid_w_i_h = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (bus.instr_ready_w_o_h !== 1'b0 || bus.dec_valid_w_o_h !== 1'b1 || outs() !== ea) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got ready=%b valid=%b outs=%h expected ready=0 valid=1 outs=%h",
                 c, bus.instr_ready_w_o_h, bus.dec_valid_w_o_h, outs(), ea);
      end
      if (c == 0) begin
        @(posedge clk); #1;
      end
    end
    bus.dec_ready_w_i_h = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.instr_ready_w_o_h !== 1'b1 || bus.dec_valid_w_o_h !== 1'b1 || outs() !== eb) begin
      errors++;
      $display("FAIL stall_second: got ready=%b valid=%b outs=%h expected ready=1 valid=1 outs=%h",
               bus.instr_ready_w_o_h, bus.dec_valid_w_o_h, outs(), eb);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.dec_valid_w_o_h !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: got valid=%b expected 0", bus.dec_valid_w_o_h);
    end
  endtask

  task automatic fill_skid();
    bus.dec_ready_w_i_h   = 1'b0;
    bus.instr_w_i         = 32'h402081B3;
    bus.instr_valid_w_i_h = 1'b1;
    @(posedge clk); #1;
    bus.instr_w_i = 32'hFFF00093;
    @(posedge clk); #1;
    bus.instr_valid_w_i_h = 1'b0;
  endtask

  task automatic test_flush();
    fill_skid();
    bus.flush_w_i_h       = 1'b1;
    bus.instr_w_i         = 32'h123450B7;
    bus.instr_valid_w_i_h = 1'b1;
    @(posedge clk); #1;
    bus.flush_w_i_h       = 1'b0;
    bus.instr_valid_w_i_h = 1'b0;
    checks++;
    if (bus.dec_valid_w_o_h !== 1'b0 || bus.instr_ready_w_o_h !== 1'b1) begin
      errors++;
      $display("FAIL flush_full: got valid=%b ready=%b expected valid=0 ready=1",
               bus.dec_valid_w_o_h, bus.instr_ready_w_o_h);
    end
    bus.dec_ready_w_i_h = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.dec_valid_w_o_h !== 1'b0) begin
        errors++;
        $display("FAIL flush_quiet[%0d]: got valid=%b imm=%h expected valid=0",
                 c, bus.dec_valid_w_o_h, bus.imm_w_o);
      end
    end
    bus.flush_w_i_h       = 1'b1;
    bus.instr_valid_w_i_h = 1'b1;
    @(posedge clk); #1;
    bus.flush_w_i_h = 1'b0;
    bus.instr_valid_w_i_h = 1'b0;
    checks++;
    if (bus.dec_valid_w_o_h !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: got valid=%b expected 0", bus.dec_valid_w_o_h);
    end
    bus.instr_w_i         = 32'h008000EF;
    bus.instr_valid_w_i_h = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid_w_i_h = 1'b0;
    checks++;
    if (bus.dec_valid_w_o_h !== 1'b1 || bus.imm_w_o !== 32'h00000008 || bus.b_sel_imm_w_o_h !== 1'b1) begin
      errors++;
      $display("FAIL flush_recover: got valid=%b imm=%h bsel=%b expected valid=1 imm=00000008 bsel=1",
               bus.dec_valid_w_o_h, bus.imm_w_o, bus.b_sel_imm_w_o_h);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstall();
    fill_skid();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.dec_valid_w_o_h !== 1'b0 || bus.instr_ready_w_o_h !== 1'b1 || outs() !== 44'h0) begin
      errors++;
      $display("FAIL rst_mid_immediate: got valid=%b ready=%b outs=%h expected valid=0 ready=1 outs=0",
               bus.dec_valid_w_o_h, bus.instr_ready_w_o_h, outs());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.dec_ready_w_i_h = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.dec_valid_w_o_h !== 1'b0 || bus.instr_ready_w_o_h !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_discard[%0d]: got valid=%b ready=%b expected valid=0 ready=1",
                 c, bus.dec_valid_w_o_h, bus.instr_ready_w_o_h);
      end
    end
  endtask

  initial begin
    bus.instr_w_i         = 32'h0;
    bus.instr_valid_w_i_h = 1'b0;
    bus.flush_w_i_h       = 1'b0;
    bus.dec_ready_w_i_h   = 1'b1;
    test_reset();
    test_decode();
    test_stall();
    test_flush();
    test_reset_midstall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
